// File: rtl/sm_cpu_core.sv
// sm_cpu_core: single-cycle 32-bit MIPS-subset core (schoolMIPS style).
// One instruction is fetched from an external combinational ROM and executed
// every clock. A combinational debug port returns the PC or any register.

// sm_register_file: 32 x 32-bit registers, two read ports for the datapath,
// a third read port for debug, and one synchronous write port. r0 reads as 0.
module sm_register_file (
   input  logic        clk,
   input  logic [4:0]  a1,
   input  logic [4:0]  a2,
   input  logic [4:0]  a3,
   output logic [31:0] rd1,
   output logic [31:0] rd2,
   output logic [31:0] rd3,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [31:0] wd
);
   logic [31:0] rf [0:31];

   // r0 is hard-wired to zero on every read port, whatever the array holds.
   assign rd1 = (a1 != 5'd0) ? rf[a1] : 32'd0;
   assign rd2 = (a2 != 5'd0) ? rf[a2] : 32'd0;
   assign rd3 = (a3 != 5'd0) ? rf[a3] : 32'd0;

   // Single write per rising edge; writes aimed at r0 are dropped.
   // NOTE: the storage array has no reset; contents survive a core reset and
   // are set up by software, which also keeps it mappable to plain RAM.
   always_ff @(posedge clk) begin
      if (we && (wa != 5'd0)) begin
         rf[wa] <= wd;
      end
   end
endmodule

// sm_cpu_core: fetch, decode, execute and write back in one cycle.
module sm_cpu_core (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  regAddr,
   output logic [31:0] regData,
   output logic [31:0] imAddr,
   input  logic [31:0] imData
);
   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_OR,
      ALU_SLTU,
      ALU_SRL,
      ALU_LUI
   } aluOp_t;

   typedef enum logic [1:0] {
      BR_NONE,
      BR_EQ,
      BR_NE,
      BR_GEZ
   } branch_t;

   // Primary opcodes
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BGEZ  = 6'b000001;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_LUI   = 6'b001111;

   // R-type function codes
   localparam logic [5:0] FN_SRL   = 6'b000010;
   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_SLTU  = 6'b101011;

   // Architectural PC, a word index into instruction memory
   logic [31:0] pc;
   logic [31:0] pcNext;
   logic [31:0] pcPlus1;
   logic [31:0] pcBranch;

   // Instruction and its fields
   logic [31:0] instr;
   logic [5:0]  op;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  sa;
   logic [5:0]  funct;
   logic [15:0] imm;
   logic [31:0] immSext;

   // Decoded control
   logic        regWrite;
   logic        regDst;
   logic        aluSrcImm;
   aluOp_t      aluOp;
   branch_t     branch;

   // Datapath
   logic [31:0] rsData;
   logic [31:0] rtData;
   logic [31:0] dbgData;
   logic [31:0] aluB;
   logic [31:0] aluResult;
   logic [4:0]  writeReg;
   logic        branchTaken;

   assign instr   = imData;
   assign op      = instr[31:26];
   assign rs      = instr[25:21];
   assign rt      = instr[20:16];
   assign rd      = instr[15:11];
   assign sa      = instr[10:6];
   assign funct   = instr[5:0];
   assign imm     = instr[15:0];
   assign immSext = {{16{imm[15]}}, imm};

   // Decode: anything not recognised falls through to the defaults, which
   // leave the machine state untouched apart from PC + 1.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      regWrite  = 1'b0;
      regDst    = 1'b0;
      aluSrcImm = 1'b0;
      aluOp     = ALU_ADD;
      branch    = BR_NONE;
      case (op)
         OP_RTYPE: begin
            regDst = 1'b1;
            case (funct)
               FN_ADDU: begin regWrite = 1'b1; aluOp = ALU_ADD;  end
               FN_SUBU: begin regWrite = 1'b1; aluOp = ALU_SUB;  end
               FN_OR:   begin regWrite = 1'b1; aluOp = ALU_OR;   end
               FN_SLTU: begin regWrite = 1'b1; aluOp = ALU_SLTU; end
               FN_SRL:  begin regWrite = 1'b1; aluOp = ALU_SRL;  end
               default: regWrite = 1'b0;
            endcase
         end
         OP_ADDIU: begin
            regWrite  = 1'b1;
            aluSrcImm = 1'b1;
            aluOp     = ALU_ADD;
         end
         OP_LUI: begin
            regWrite  = 1'b1;
            aluSrcImm = 1'b1;
            aluOp     = ALU_LUI;
         end
         OP_BEQ:  branch = BR_EQ;
         OP_BNE:  branch = BR_NE;
         OP_BGEZ: branch = BR_GEZ;
         default: branch = BR_NONE;
      endcase
   end

   // Register file; writes are held off while the core is in reset so a
   // reset mid-program leaves register contents intact.
   sm_register_file rf (
      .clk (clk),
      .a1  (rs),
      .a2  (rt),
      .a3  (regAddr),
      .rd1 (rsData),
      .rd2 (rtData),
      .rd3 (dbgData),
      .we  (regWrite & ~rst),
      .wa  (writeReg),
      .wd  (aluResult)
   );

   assign writeReg = regDst ? rd : rt;
   assign aluB     = aluSrcImm ? immSext : rtData;

   // ALU: operand A is rs, operand B is rt or the sign-extended immediate.
   always_comb begin
      aluResult = 32'd0;
      case (aluOp)
         ALU_ADD:  aluResult = rsData + aluB;
         ALU_SUB:  aluResult = rsData - aluB;
         ALU_OR:   aluResult = rsData | aluB;
         ALU_SLTU: aluResult = {31'd0, (rsData < aluB)};
         ALU_SRL:  aluResult = aluB >> sa;
         ALU_LUI:  aluResult = {aluB[15:0], 16'h0000};
         default:  aluResult = 32'd0;
      endcase
   end

   // Branch decision; BGEZ looks only at the sign of rs.
   always_comb begin
      branchTaken = 1'b0;
      case (branch)
         BR_EQ:   branchTaken = (rsData == rtData);
         BR_NE:   branchTaken = (rsData != rtData);
         BR_GEZ:  branchTaken = ~rsData[31];
         default: branchTaken = 1'b0;
      endcase
   end

   assign pcPlus1  = pc + 32'd1;
   assign pcBranch = pcPlus1 + immSext;
   assign pcNext   = branchTaken ? pcBranch : pcPlus1;

   // PC register: cleared asynchronously, otherwise advances every edge.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state is written with non-blocking assignments so every
      // register samples pre-edge values, regardless of block ordering.
      if (rst) begin
         pc <= 32'd0;
      end else begin
         pc <= pcNext;
      end
   end

   assign imAddr  = pc;
   assign regData = (regAddr == 5'd0) ? pc : dbgData;
endmodule

// File: tb/tb_sm_cpu_core.sv
// Directed testbench for sm_cpu_core: a local ROM array feeds imData, the
// debug port is used to read back PC and registers at the falling edge.
module tb_sm_cpu_core;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  regAddr = 5'd0;
   logic [31:0] regData;
   logic [31:0] imAddr;
   logic [31:0] imData;

   logic [31:0] rom [0:63];

   int vecCount  = 0;
   int missCount = 0;

   logic [31:0] expA [0:17] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6,
                                32'd7, 32'd8, 32'd9, 32'd10, 32'd13, 32'd14,
                                32'd15, 32'd16, 32'd17, 32'd17, 32'd17, 32'd17};
   logic [31:0] fibTab [0:9] = '{32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8,
                                 32'd13, 32'd21, 32'd34, 32'd55};

   assign imData = rom[imAddr[5:0]];

   sm_cpu_core dut (
      .clk     (clk),
      .rst     (rst),
      .regAddr (regAddr),
      .regData (regData),
      .imAddr  (imAddr),
      .imData  (imData)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      vecCount++;
      if (actual !== expected) begin
         missCount++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, actual, expected, $time);
      end
   endtask

   task automatic checkReg(input string tag, input logic [4:0] r, input logic [31:0] expected);
      regAddr = r;
      #1;
      check(tag, regData, expected);
      regAddr = 5'd0;
   endtask

   task automatic checkPc(input string tag, input logic [31:0] expected);
      check({tag, "_imAddr"}, imAddr, expected);
      regAddr = 5'd0;
      #1;
      check({tag, "_regData"}, regData, expected);
   endtask

   function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sa,
                                         input logic [5:0] funct);
      return {6'b000000, rs, rt, rd, sa, funct};
   endfunction

   function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic clearRom();
      for (int i = 0; i < 64; i++) rom[i] = 32'd0;
   endtask

   // Pulse reset across one rising edge, release at a falling edge.
   task automatic startProg();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] expPc;
      logic [31:0] prevPc;
      int          iter;

      clearRom();

      // Reset held for 4 cycles, then PC counts through a nop ROM
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkPc($sformatf("reset_hold%0d", i), 32'd0);
      end
      rst = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         checkPc($sformatf("nop_run%0d", i), i);
      end

      // Reset must clear PC asynchronously, without waiting for an edge
      #2;
      rst = 1'b1;
      #1;
      check("async_reset_pc", imAddr, 32'd0);

      // Clear r1..r31 with addiu $i,$0,0
      for (int i = 1; i < 32; i++) rom[i-1] = iType(6'h09, 5'd0, 5'(i), 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      repeat (31) @(negedge clk);
      checkPc("init_done", 32'd31);

      // Arithmetic, logic, shift, compare, branches, r0 and unknown opcode
      clearRom();
      rom[0]  = iType(6'h09, 5'd0, 5'd2, 16'd5);          // addiu $2,$0,5
      rom[1]  = iType(6'h09, 5'd0, 5'd3, 16'hFFFF);       // addiu $3,$0,-1
      rom[2]  = rType(5'd2, 5'd3, 5'd4, 5'd0, 6'h21);     // addu  $4,$2,$3
      rom[3]  = rType(5'd2, 5'd3, 5'd5, 5'd0, 6'h23);     // subu  $5,$2,$3
      rom[4]  = iType(6'h0F, 5'd0, 5'd6, 16'h8000);       // lui   $6,0x8000
      rom[5]  = rType(5'd0, 5'd6, 5'd7, 5'd4, 6'h02);     // srl   $7,$6,4
      rom[6]  = rType(5'd7, 5'd2, 5'd8, 5'd0, 6'h25);     // or    $8,$7,$2
      rom[7]  = rType(5'd2, 5'd6, 5'd9, 5'd0, 6'h2B);     // sltu  $9,$2,$6
      rom[8]  = iType(6'h09, 5'd0, 5'd0, 16'd7);          // addiu $0,$0,7
      rom[9]  = iType(6'h09, 5'd0, 5'd10, 16'h0055);      // addiu $10,$0,0x55
      rom[10] = iType(6'h04, 5'd0, 5'd0, 16'd2);          // beq   $0,$0,+2
      rom[11] = iType(6'h09, 5'd0, 5'd11, 16'd1);         // skipped
      rom[12] = iType(6'h09, 5'd0, 5'd11, 16'd2);         // skipped
      rom[13] = iType(6'h05, 5'd2, 5'd2, 16'd2);          // bne   $2,$2,+2
      rom[14] = iType(6'h01, 5'd3, 5'd1, 16'd2);          // bgez  $3,+2
      rom[15] = {6'h3F, 5'd0, 5'd10, 16'h1234};           // unknown opcode
      rom[16] = rType(5'd3, 5'd2, 5'd12, 5'd0, 6'h2B);    // sltu  $12,$3,$2
      rom[17] = iType(6'h01, 5'd0, 5'd1, 16'hFFFF);       // bgez  $0,-1
      startProg();
      for (int k = 0; k < 18; k++) begin
         @(negedge clk);
         check($sformatf("progA_pc%0d", k), imAddr, expA[k]);
      end
      checkReg("r2_addiu",      5'd2,  32'd5);
      checkReg("r3_addiu_neg",  5'd3,  32'hFFFF_FFFF);
      checkReg("r4_addu_wrap",  5'd4,  32'd4);
      checkReg("r5_subu_wrap",  5'd5,  32'd6);
      checkReg("r6_lui",        5'd6,  32'h8000_0000);
      checkReg("r7_srl",        5'd7,  32'h0800_0000);
      checkReg("r8_or",         5'd8,  32'h0800_0005);
      checkReg("r9_sltu_true",  5'd9,  32'd1);
      checkReg("r10_unknown_op",5'd10, 32'h0000_0055);
      checkReg("r11_beq_skip",  5'd11, 32'd0);
      checkReg("r12_sltu_false",5'd12, 32'd0);
      checkReg("r0_reads_zero", 5'd0,  32'd17);           // debug 0 is PC
      check("r0_write_ignored_pc", imAddr, 32'd17);

      // Reset mid-program: PC clears, registers survive, writes suppressed
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("mid_reset_async_pc", imAddr, 32'd0);
      rom[0] = iType(6'h09, 5'd0, 5'd13, 16'h0077);       // addiu $13,$0,0x77
      repeat (2) @(negedge clk);
      checkPc("mid_reset_hold", 32'd0);
      checkReg("mid_reset_r13_blocked", 5'd13, 32'd0);
      checkReg("mid_reset_r2_kept",     5'd2,  32'd5);
      rst = 1'b0;
      @(negedge clk);
      checkPc("after_reset_pc", 32'd1);
      checkReg("after_reset_r13", 5'd13, 32'h0000_0077);

      // Fibonacci: v0 ($2) steps through 1,1,2,3,5,... at each bne
      clearRom();
      rom[0] = iType(6'h09, 5'd0, 5'd2, 16'd0);           // addiu $2,$0,0
      rom[1] = iType(6'h09, 5'd0, 5'd3, 16'd1);           // addiu $3,$0,1
      rom[2] = iType(6'h09, 5'd0, 5'd5, 16'd10);          // addiu $5,$0,10
      rom[3] = rType(5'd2, 5'd3, 5'd4, 5'd0, 6'h21);      // addu  $4,$2,$3
      rom[4] = rType(5'd3, 5'd0, 5'd2, 5'd0, 6'h25);      // or    $2,$3,$0
      rom[5] = rType(5'd4, 5'd0, 5'd3, 5'd0, 6'h25);      // or    $3,$4,$0
      rom[6] = iType(6'h09, 5'd5, 5'd5, 16'hFFFF);        // addiu $5,$5,-1
      rom[7] = iType(6'h05, 5'd5, 5'd0, 16'hFFFB);        // bne   $5,$0,-5
      rom[8] = iType(6'h01, 5'd0, 5'd1, 16'hFFFF);        // bgez  $0,-1
      startProg();
      expPc = 32'd0;
      iter  = 0;
      for (int c = 0; c < 120; c++) begin
         prevPc = expPc;
         if (expPc == 32'd7) begin
            iter++;
            expPc = (iter < 10) ? 32'd3 : 32'd8;
         end else if (expPc == 32'd8) begin
            expPc = 32'd8;
         end else begin
            expPc = expPc + 32'd1;
         end
         @(negedge clk);
         checkPc($sformatf("fib_c%0d", c), expPc);
         if (prevPc == 32'd7) checkReg($sformatf("fib_v0_it%0d", iter), 5'd2, fibTab[iter-1]);
      end
      checkReg("fib_counter_done", 5'd5, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end
endmodule
